// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, flag indices, FSM states and flag masks for seq_alu
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_XOR  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_SLL  = 4'd4;
  localparam logic [3:0] OP_SRA  = 4'd5;
  localparam logic [3:0] OP_ROR  = 4'd6;
  localparam logic [3:0] OP_LLB  = 4'd7;
  localparam logic [3:0] OP_LHB  = 4'd8;
  localparam logic [3:0] OP_PASS = 4'd9;

  localparam int FLAG_N = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_V = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Indexed by opcode: ADD/SUB write V/Z/N, logic and shift ops write Z, the rest write nothing.
  localparam logic [15:0][2:0] FLAG_MASK = {{9{3'b000}}, {5{3'b010}}, {2{3'b111}}};

  function automatic logic is_shift(input logic [3:0] op);
    return (op == OP_SLL) || (op == OP_SRA) || (op == OP_ROR);
  endfunction

endpackage

// File: rtl/addsub_sat.sv
// rtl/addsub_sat.sv - combinational saturating two's-complement add/subtract with overflow flag
module addsub_sat #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             ovfl
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] raw;

  assign b_eff = sub ? ~b : b;
  assign raw   = a + b_eff + {{(WIDTH-1){1'b0}}, sub};
  // Overflow only when both addends share a sign that the raw sum lost.
  assign ovfl  = (a[WIDTH-1] == b_eff[WIDTH-1]) && (raw[WIDTH-1] != a[WIDTH-1]);

  always_comb begin
    sum = raw;
    if (ovfl) sum = a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  end

endmodule

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - handshake ALU with iterative shifts, selective V/Z/N flags and illegal-op error
module seq_alu
  import alu_pkg::*;
#(
  parameter  int WIDTH   = 16,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             err,
  output logic [2:0]       flags
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               err_q, err_d;
  logic [2:0]         flags_q, flags_d;
  logic [WIDTH-1:0]   sh_q, sh_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [3:0]         op_q, op_d;

  logic [WIDTH-1:0]   as_sum;
  logic               as_ovfl;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   sh_next;
  logic [WIDTH-1:0]   res_c;
  logic               err_c;
  logic [2:0]         mask_c;
  logic [2:0]         fnew_c;
  logic               done_c;

  addsub_sat #(.WIDTH(WIDTH)) u_addsub (
    .a    (a),
    .b    (b),
    .sub  (op == OP_SUB),
    .sum  (as_sum),
    .ovfl (as_ovfl)
  );

  function automatic logic [WIDTH-1:0] shift1(input logic [3:0] o, input logic [WIDTH-1:0] v);
    case (o)
      OP_SLL:  return {v[WIDTH-2:0], 1'b0};
      OP_SRA:  return {v[WIDTH-1], v[WIDTH-1:1]};
      default: return {v[0], v[WIDTH-1:1]};
    endcase
  endfunction

  assign shamt     = b[SHAMT_W-1:0];
  assign sh_next   = shift1(op_q, sh_q);
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign err       = err_q;
  assign flags     = flags_q;

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    err_d    = err_q;
    flags_d  = flags_q;
    sh_d     = sh_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    res_c    = '0;
    err_c    = 1'b0;
    mask_c   = 3'b000;
    done_c   = 1'b0;
    fnew_c   = 3'b000;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d = op;
          if (is_shift(op) && (shamt != '0)) begin
            sh_d    = a;
            cnt_d   = shamt;
            state_d = SHIFT;
          end else begin
            done_c = 1'b1;
            mask_c = FLAG_MASK[op];
            case (op)
              OP_ADD, OP_SUB:         res_c = as_sum;
              OP_XOR:                 res_c = a ^ b;
              OP_AND:                 res_c = a & b;
              OP_SLL, OP_SRA, OP_ROR: res_c = a;
              OP_LLB:                 res_c = {a[WIDTH-1:8], b[7:0]};
              OP_LHB:                 res_c = {b[7:0], a[WIDTH-9:0]};
              OP_PASS:                res_c = a;
              default: begin
                res_c = '0;
                err_c = 1'b1;
              end
            endcase
          end
        end
      end
      SHIFT: begin
        sh_d  = sh_next;
        cnt_d = cnt_q - SHAMT_W'(1);
        if (cnt_q == SHAMT_W'(1)) begin
          done_c = 1'b1;
          res_c  = sh_next;
          mask_c = FLAG_MASK[op_q];
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // V only ever survives the mask on an ADD/SUB accept, where the adder sees the live operands.
    fnew_c[FLAG_V] = as_ovfl;
    fnew_c[FLAG_Z] = (res_c == '0);
    fnew_c[FLAG_N] = res_c[WIDTH-1];

    if (done_c) begin
      state_d  = DONE;
      result_d = res_c;
      err_d    = err_c;
      flags_d  = (flags_q & ~mask_c) | (fnew_c & mask_c);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      result_q <= '0;
      err_q    <= 1'b0;
      flags_q  <= 3'b000;
      sh_q     <= '0;
      cnt_q    <= '0;
      op_q     <= 4'd0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      err_q    <= err_d;
      flags_q  <= flags_d;
      sh_q     <= sh_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
    end
  end

endmodule
